// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and default constants for the elevator scheduler
//
// Purpose: controller state encoding, travel direction encoding and the
// default sizing/timing constants used by elevator_scheduler and floor_cmp.
// Ports: none (package).
package elevator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN,
    HALT
  } state_t;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

  localparam int N_FLOORS_DEF      = 4;
  localparam int FLOOR_W_DEF       = 2;
  localparam int TRAVEL_CYCLES_DEF = 8;
  localparam int DOOR_CYCLES_DEF   = 4;

endpackage

// File: rtl/elevator_scheduler_floor_cmp.sv
// rtl/elevator_scheduler_floor_cmp.sv - combinational floor position comparator
//
// Purpose: compares a floor index against the target floor.
// Ports:
//   rst  in  1        active-low reset; forces all flags to 0 while asserted
//   a    in  FLOOR_W  floor under test
//   b    in  FLOOR_W  target floor
//   lt   out 1        a < b
//   gt   out 1        a > b
//   eq   out 1        a == b
module floor_cmp
  import elevator_pkg::*;
#(
  parameter int FLOOR_W = FLOOR_W_DEF
) (
  input  logic               rst,
  input  logic [FLOOR_W-1:0] a,
  input  logic [FLOOR_W-1:0] b,
  output logic               lt,
  output logic               gt,
  output logic               eq
);

  always_comb begin
    lt = rst && (a < b);
    gt = rst && (a > b);
    eq = rst && (a == b);
  end

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - SCAN elevator sequencing controller
//
// Purpose: latches floor requests, picks the next target with SCAN, drives the
// motor/door outputs and owns the current-floor register.
// Optional feature: ELEV_EMERG_STOP_EN adds the estop input and the HALT state.
// Ports:
//   clk            in  1         system clock, rising edge
//   rst            in  1         asynchronous active-low reset
//   estop          in  1         emergency stop (only with ELEV_EMERG_STOP_EN)
//   req_btn        in  N_FLOORS  floor request buttons
//   current_floor  out FLOOR_W   registered car position
//   target_floor   out FLOOR_W   floor being served (current_floor when idle)
//   pending        out N_FLOORS  latched unserved requests
//   motor_up       out 1         car moving up
//   motor_down     out 1         car moving down
//   door_open      out 1         door held open
//   busy           out 1         state is not IDLE
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS      = N_FLOORS_DEF,
  parameter int FLOOR_W       = FLOOR_W_DEF,
  parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
`ifdef ELEV_EMERG_STOP_EN
  input  logic                estop,
`endif
  input  logic [N_FLOORS-1:0] req_btn,
  output logic [FLOOR_W-1:0]  current_floor,
  output logic [FLOOR_W-1:0]  target_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                motor_up,
  output logic                motor_down,
  output logic                door_open,
  output logic                busy
);

  localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TRAVEL_LD = TMR_W'(TRAVEL_CYCLES);
  localparam logic [TMR_W-1:0] DOOR_LD   = TMR_W'(DOOR_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  state_t               state_q, state_nx;
  dir_t                 dir_q, dir_nx;
  logic [FLOOR_W-1:0]   cur_q, floor_nx;
  logic [FLOOR_W-1:0]   target_q, target_nx;
  logic [N_FLOORS-1:0]  pending_q, pending_nx;
  logic [TMR_W-1:0]     trav_q, trav_nx;
  logic [TMR_W-1:0]     door_q, door_nx;
  logic [N_FLOORS-1:0]  served_mask, req_mask;

  // Floor the car reaches when the current travel timer expires.
  logic [FLOOR_W-1:0]   step_floor;
  logic                 cmp_lt, cmp_gt, cmp_eq;

  // Nearest pending floor above/below the car, and ahead of step_floor.
  logic                 up_hit, dn_hit, step_up_hit, step_dn_hit;
  logic [FLOOR_W-1:0]   up_idx, dn_idx, step_up_idx, step_dn_idx;

  // Lowest pending floor strictly above f; MSB flags a hit.
  function automatic logic [FLOOR_W:0] near_above(input logic [N_FLOORS-1:0] p,
                                                  input logic [FLOOR_W-1:0] f);
    logic [FLOOR_W:0] r;
    r = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--)
      if (p[i] && (i > int'(f))) r = {1'b1, FLOOR_W'(i)};
    return r;
  endfunction

  // Highest pending floor strictly below f; MSB flags a hit.
  function automatic logic [FLOOR_W:0] near_below(input logic [N_FLOORS-1:0] p,
                                                  input logic [FLOOR_W-1:0] f);
    logic [FLOOR_W:0] r;
    r = '0;
    for (int i = 0; i < N_FLOORS; i++)
      if (p[i] && (i < int'(f))) r = {1'b1, FLOOR_W'(i)};
    return r;
  endfunction

  always_comb begin
    step_floor = cur_q;
    if (state_q == MOVE_UP)   step_floor = cur_q + FLOOR_W'(1);
    if (state_q == MOVE_DOWN) step_floor = cur_q - FLOOR_W'(1);
  end

  always_comb begin
    {up_hit, up_idx}           = near_above(pending_q, cur_q);
    {dn_hit, dn_idx}           = near_below(pending_q, cur_q);
    {step_up_hit, step_up_idx} = near_above(pending_q, step_floor);
    {step_dn_hit, step_dn_idx} = near_below(pending_q, step_floor);
  end

  floor_cmp #(.FLOOR_W(FLOOR_W)) u_cmp (
    .rst (rst),
    .a   (step_floor),
    .b   (target_q),
    .lt  (cmp_lt),
    .gt  (cmp_gt),
    .eq  (cmp_eq)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dir_q     <= UP;
      cur_q     <= '0;
      target_q  <= '0;
      pending_q <= '0;
      trav_q    <= '0;
      door_q    <= '0;
    end else begin
      state_q   <= state_nx;
      dir_q     <= dir_nx;
      cur_q     <= floor_nx;
      target_q  <= target_nx;
      pending_q <= pending_nx;
      trav_q    <= trav_nx;
      door_q    <= door_nx;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nx    = state_q;
    dir_nx      = dir_q;
    floor_nx    = cur_q;
    target_nx   = target_q;
    trav_nx     = trav_q;
    door_nx     = door_q;
    served_mask = '0;
    req_mask    = '1;

    case (state_q)
      IDLE: begin
        target_nx = cur_q;
        if (pending_q[cur_q]) begin
          state_nx           = DOOR_OPEN;
          door_nx            = DOOR_LD;
          served_mask[cur_q] = 1'b1;
        end else if (dir_q == UP && up_hit) begin
          state_nx  = MOVE_UP;
          target_nx = up_idx;
          trav_nx   = TRAVEL_LD;
        end else if (dn_hit) begin
          state_nx  = MOVE_DOWN;
          dir_nx    = DOWN;
          target_nx = dn_idx;
          trav_nx   = TRAVEL_LD;
        end else if (up_hit) begin
          state_nx  = MOVE_UP;
          dir_nx    = UP;
          target_nx = up_idx;
          trav_nx   = TRAVEL_LD;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (trav_q <= TMR_ONE) begin
          floor_nx = step_floor;
          if (cmp_eq || pending_q[step_floor]) begin
            // Target reached or a pickup on the way.
            state_nx                = DOOR_OPEN;
            door_nx                 = DOOR_LD;
            trav_nx                 = '0;
            target_nx               = step_floor;
            served_mask[step_floor] = 1'b1;
          end else if (state_q == MOVE_UP && cmp_lt && step_up_hit) begin
            trav_nx   = TRAVEL_LD;
            target_nx = step_up_idx;
          end else if (state_q == MOVE_DOWN && cmp_gt && step_dn_hit) begin
            trav_nx   = TRAVEL_LD;
            target_nx = step_dn_idx;
          end else begin
            state_nx  = IDLE;
            trav_nx   = '0;
            target_nx = step_floor;
          end
        end else begin
          trav_nx = trav_q - TMR_ONE;
        end
      end

      DOOR_OPEN: begin
        // A press for this floor holds the door instead of queueing a request.
        req_mask[cur_q] = 1'b0;
        if (req_btn[cur_q]) begin
          door_nx = DOOR_LD;
        end else if (door_q <= TMR_ONE) begin
          state_nx = IDLE;
          door_nx  = '0;
        end else begin
          door_nx = door_q - TMR_ONE;
        end
      end

      default: begin
        // HALT: leaving it re-runs the IDLE decision, restarting any move.
        state_nx  = IDLE;
        target_nx = cur_q;
      end
    endcase

`ifdef ELEV_EMERG_STOP_EN
    if (estop) begin
      state_nx    = HALT;
      dir_nx      = dir_q;
      floor_nx    = cur_q;
      target_nx   = target_q;
      trav_nx     = trav_q;
      door_nx     = door_q;
      served_mask = '0;
      req_mask    = '1;
    end
`endif

    pending_nx = (pending_q | (req_btn & req_mask)) & ~served_mask;
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    motor_up      = (state_q == MOVE_UP);
    motor_down    = (state_q == MOVE_DOWN);
    door_open     = (state_q == DOOR_OPEN);
    busy          = (state_q != IDLE);
    current_floor = cur_q;
    target_floor  = target_q;
    pending       = pending_q;
  end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Sequencing controller for the elevator floor datapath.
- Latches floor-button requests and selects the next target floor using SCAN (keep travelling in the current direction while requests lie ahead).
- Drives motor up/down and door outputs, and owns the current-floor register.
- Instantiates the floor compare function to decide up, down or arrived.

Parameters:
- N_FLOORS, 4, number of floors; floors are 0..N_FLOORS-1.
- FLOOR_W, 2, floor index width; must satisfy 2**FLOOR_W >= N_FLOORS.
- TRAVEL_CYCLES, 8, clock cycles to travel one floor; minimum 1.
- DOOR_CYCLES, 4, clock cycles the door is held open; minimum 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- req_btn  input  N_FLOORS  one bit per floor; a level or pulse sets the pending request for that floor.
- current_floor  output  FLOOR_W  registered floor position.
- target_floor  output  FLOOR_W  floor currently being served; equals current_floor when idle.
- pending  output  N_FLOORS  latched, not-yet-served requests.
- motor_up  output  1  car moving up.
- motor_down  output  1  car moving down.
- door_open  output  1  door held open.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, current_floor=0, target_floor=0, pending=0, dir=UP.
  - motor_up, motor_down, door_open and busy all 0; both timers 0.
  - Reset mid-move aborts the move; the car is modelled back at floor 0.
- Request latch, every cycle: pending <= (pending | req_btn) & ~served_mask.
  - served_mask has one bit set, for current_floor, only in the cycle an arrival or door service occurs.
  - If a request and the clear for the same floor occur in the same cycle, the clear wins.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. All outputs are Moore outputs, registered from state.
- IDLE:
  - If pending[current_floor]=1: go to DOOR_OPEN next cycle, clear the bit, load the door timer.
  - Otherwise, if dir=UP and any request lies above: go to MOVE_UP, target = nearest pending floor above.
  - Otherwise, if any request lies below: go to MOVE_DOWN, dir=DOWN, target = nearest pending floor below.
  - Otherwise, if any request lies above: go to MOVE_UP, dir=UP.
  - Otherwise stay in IDLE.
  - Decision latency is 1 cycle from the request becoming visible in pending.
- MOVE_UP / MOVE_DOWN:
  - motor_up or motor_down is 1; the travel timer counts TRAVEL_CYCLES.
  - On expiry, current_floor is incremented or decremented by 1.
  - On expiry, if the comparator reports the new floor equal to target, or pending[new floor]=1 (a pickup on the way): go to DOOR_OPEN and clear that bit.
  - Otherwise reload the timer and continue; target is re-evaluated as the nearest pending floor ahead.
  - Floor never wraps: a move is never started past 0 or N_FLOORS-1. If no request remains ahead, return to IDLE.
- DOOR_OPEN:
  - door_open=1 for DOOR_CYCLES, then go to IDLE.
  - A new req_btn for current_floor during DOOR_OPEN restarts the door timer and is not latched.
- Motors and door are mutually exclusive in every cycle.
- Timer widths are $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1).

Optional Feature:
- Macro ELEV_EMERG_STOP_EN.
- Defined:
  - Adds input port estop (1 bit) and a HALT state.
  - While estop=1, any state goes to HALT next cycle: motors off, door_open=0, timers frozen, requests still latched.
  - On estop falling, go to IDLE. If the travel timer was frozen non-zero, current_floor is unchanged and the move restarts.
- Undefined: no estop port and no HALT state; behaviour as above.

Decomposition:
- Package elevator_pkg holds:
  - the state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, HALT);
  - the dir_t enum (UP, DOWN);
  - default constants for N_FLOORS, FLOOR_W and the timer defaults.
- One sub-module, floor_cmp: combinational compare of current_floor vs target_floor, giving lt, gt, eq, with rst gating all outputs to 0.
- Nearest-request search (priority encode above and below current_floor) stays in elevator_scheduler.

Test Plan:
- Reset: rst=0 during MOVE_UP -> all outputs 0 and current_floor=0 immediately (asynchronous); after release, state is IDLE.
- Same-floor request: req_btn=4'b0001 at floor 0 -> door_open=1 for 4 cycles, pending=0, no motor activity.
- Single trip: req_btn=4'b1000 from floor 0 -> motor_up for 24 cycles, current_floor steps 1, 2, 3, then door_open for 4 cycles, then busy=0.
- SCAN pickup: at floor 0 request floor 3, then request floor 1 during the first travel -> stop at floor 1 with door open, then continue to floor 3.
- Direction reversal: car at floor 2 going UP with only floor 0 pending -> MOVE_DOWN, dir=DOWN, arrives at floor 0 after 16 cycles.
- Door extend and simultaneous events: req_btn for current floor on door cycle 3 -> door timer restarts and pending bit stays 0. With ELEV_EMERG_STOP_EN defined, estop=1 mid-move freezes motors and the floor; release resumes the move.
